// File: rtl/mult_control.sv
// Sequencer for the shift-add signed multiplier: walks N_BITS add/shift steps, subtracting on the last.
// Optional macro MULT_CTRL_AUTO_CLR_EN inserts a CLR state so every multiply starts from A=X=0.
module mult_control #(
    parameter int N_BITS = 8
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic Run,
    input  logic ClearA_LoadB,
    input  logic M,
    output logic Clr_Ld,
    output logic Clr_XA,
    output logic Add,
    output logic Sub,
    output logic Shift_En,
    output logic Busy,
    output logic Done
);
    localparam int CW = $clog2(N_BITS);
    localparam logic [CW-1:0] LAST = CW'(N_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_ADD,
        S_SHIFT,
        S_HOLD
    } state_t;

    state_t          state;
    state_t          nxt;
    logic [CW-1:0]   cnt;
    logic            last;

    assign last = (cnt == LAST);

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE: begin
                if (Run) begin
`ifdef MULT_CTRL_AUTO_CLR_EN
                    nxt = S_CLR;
`else
                    nxt = S_ADD;
`endif
                end
            end
            S_CLR:   nxt = S_ADD;
            S_ADD:   nxt = S_SHIFT;
            S_SHIFT: nxt = last ? S_HOLD : S_ADD;
            S_HOLD:  if (!Run) nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // Level strobes are decoded from the next state so they line up with the state register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            Clr_XA   <= 1'b0;
            Shift_En <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            state <= nxt;
            if (state == S_IDLE || (state == S_SHIFT && last))
                cnt <= '0;
            else if (state == S_SHIFT)
                cnt <= cnt + CW'(1);
            Clr_XA   <= (nxt == S_CLR);
            Shift_En <= (nxt == S_SHIFT);
            Busy     <= (nxt == S_CLR) || (nxt == S_ADD) || (nxt == S_SHIFT);
            Done     <= (nxt == S_HOLD);
        end
    end

    // Reset_n gates Clr_Ld because the reset state itself is IDLE.
    assign Clr_Ld = Reset_n && (state == S_IDLE) && ClearA_LoadB && !Run;
    assign Add    = (state == S_ADD) && M && !last;
    assign Sub    = (state == S_ADD) && M && last;

endmodule
